// File: rtl/flatten_stream_reader_if.sv
// Bundles the flattened-buffer read port with the outgoing byte stream toward the dense layer.
interface flatten_stream_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] read_addr;
  logic              read_en;
  logic [DATA_W-1:0] read_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output read_addr, read_en, m_valid, m_data, m_last,
    input  read_data, m_ready
  );

  modport slave (
    input  read_addr, read_en, m_valid, m_data, m_last,
    output read_data, m_ready
  );
endinterface

// File: rtl/flatten_stream_reader.sv
// Sweeps the flattened feature buffer in address order and streams its bytes out,
// hiding the buffer's one-cycle read latency behind a 2-entry output FIFO.
module flatten_stream_reader #(
  parameter int DEPTH  = 1600,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  flatten_stream_reader_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic              inflight;
  logic              inflight_last;
  logic [DATA_W:0]   fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;
  logic              issue;
  logic              pop;
  logic              go_idle;
  logic              at_last_addr;
  logic [2:0]        occupancy;

  assign pop          = bus.m_valid & bus.m_ready;
  assign at_last_addr = (addr == LAST_ADDR);
  // Bytes that will still be held (FIFO plus in-flight read) once this cycle's handshake retires.
  assign occupancy    = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    go_idle    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        issue = (occupancy < 3'd2);
        if (issue && at_last_addr) state_next = DRAIN;
      end
      DRAIN: begin
        if (!inflight && occupancy == 3'd0) begin
          state_next = IDLE;
          go_idle    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue & at_last_addr;
      done          <= go_idle;
      if (go_idle)    addr <= '0;
      else if (issue) addr <= addr + ADDR_W'(1);
    end
  end

  // The last-byte flag travels with its data so m_last can never drift off byte DEPTH-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[wr_ptr] <= {inflight_last, bus.read_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign bus.read_addr = addr;
  assign bus.read_en   = issue;
  assign bus.m_valid   = (fifo_count != 2'd0);
  assign bus.m_data    = bus.m_valid ? fifo_mem[rd_ptr][DATA_W-1:0] : '0;
  assign bus.m_last    = bus.m_valid & fifo_mem[rd_ptr][DATA_W];
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_flatten_stream_reader.sv
// Scoreboard bench: full-size reader plus a 4-byte instance, each fed by a latency-1 buffer
// holding data = addr[7:0]; a negedge monitor pops expected bytes on every handshake.
module tb_flatten_stream_reader;
  localparam int DEPTH       = 1600;
  localparam int SMALL_DEPTH = 4;

  logic clk = 1'b0;
  logic resetn;
  logic start;
  logic busy;
  logic done;
  logic start_s;
  logic busy_s;
  logic done_s;

  flatten_stream_reader_if #(.ADDR_W(32), .DATA_W(8)) bus ();
  flatten_stream_reader_if #(.ADDR_W(32), .DATA_W(8)) bus_s ();

  flatten_stream_reader #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(8)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  flatten_stream_reader #(.DEPTH(SMALL_DEPTH), .ADDR_W(32), .DATA_W(8)) u_dut_small (
    .clk(clk), .resetn(resetn), .start(start_s), .busy(busy_s), .done(done_s), .bus(bus_s)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read buffers: data appears one edge after the address is sampled.
  always @(posedge clk) if (bus.read_en) bus.read_data <= bus.read_addr[7:0];
  always @(posedge clk) if (bus_s.read_en) bus_s.read_data <= bus_s.read_addr[7:0];

  bit rnd_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rnd_mode) bus.m_ready = 1'($urandom_range(0, 1));
  end

  logic [8:0] exp_q[$];
  logic [8:0] exp_q_s[$];
  logic [8:0] exp_word;
  logic [8:0] exp_word_s;
  logic [8:0] prev_word;
  bit prev_stall = 1'b0;
  bit prev_done  = 1'b0;
  int issued = 0, accepted = 0, hs_count = 0, done_count = 0;
  int first_hs_cyc = -1, done_cyc = -1, start_cyc = 0;
  int issued_s = 0, last_s = 0, done_count_s = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_read_addr"}, bus.read_addr, 32'd0);
    checkOutput({tag, "_read_en"}, 32'(bus.read_en), 32'd0);
    checkOutput({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    checkOutput({tag, "_m_data"}, 32'(bus.m_data), 32'd0);
    checkOutput({tag, "_m_last"}, 32'(bus.m_last), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Reference: an accepted start yields bytes 0..DEPTH-1 (low 8 address bits), last flag on DEPTH-1.
  task automatic applyStimulus(input bit accepted);
    @(posedge clk); #1;
    start     = 1'b1;
    start_cyc = cyc;
    if (accepted) begin
      hs_count     = 0;
      done_count   = 0;
      first_hs_cyc = -1;
      done_cyc     = -1;
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), 8'(i)});
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles);
    bit got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk); #1;
      if (done_count > 0) got = 1'b1;
    end
    checkOutput("done_seen", 32'(got), 32'd1);
  endtask

  task automatic waitHs(input int n, input int max_cycles);
    bit got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk); #1;
      if (hs_count >= n) got = 1'b1;
    end
    checkOutput("handshake_reached", 32'(got), 32'd1);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(bus.m_valid), 32'd1);
        checkOutput("stall_word", {23'd0, bus.m_last, bus.m_data}, {23'd0, prev_word});
      end
      if (bus.m_valid && bus.m_ready) begin
        accepted++;
        hs_count++;
        if (hs_count == 1) first_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("spurious_byte", {23'd0, bus.m_last, bus.m_data}, 32'hFFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("stream_byte", {23'd0, bus.m_last, bus.m_data}, {23'd0, exp_word});
        end
      end
      if (bus.read_en) begin
        checkOutput("read_addr", bus.read_addr, 32'(issued % DEPTH));
        issued++;
        checkOutput("outstanding_le2", (issued - accepted <= 2) ? 32'd1 : 32'd0, 32'd1);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        checkOutput("done_width", 32'(prev_done), 32'd0);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_word  = {bus.m_last, bus.m_data};
      prev_done  = done;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (bus_s.m_valid && bus_s.m_ready) begin
        if (bus_s.m_last) last_s++;
        if (exp_q_s.size() == 0) begin
          checkOutput("small_spurious", {23'd0, bus_s.m_last, bus_s.m_data}, 32'hFFFF_FFFF);
        end else begin
          exp_word_s = exp_q_s.pop_front();
          checkOutput("small_byte", {23'd0, bus_s.m_last, bus_s.m_data}, {23'd0, exp_word_s});
        end
      end
      if (bus_s.read_en) begin
        checkOutput("small_read_addr", bus_s.read_addr, 32'(issued_s % SMALL_DEPTH));
        issued_s++;
      end
      if (done_s) done_count_s++;
    end
  end

  initial begin
    int base;
    int seen;
    resetn        = 1'b0;
    start         = 1'b0;
    start_s       = 1'b0;
    bus.m_ready   = 1'b0;
    bus_s.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    @(posedge clk); #1;
    resetn = 1'b1;

    // Unstalled sweep: latency and done timing
    bus.m_ready = 1'b1;
    applyStimulus(1'b1);
    waitDone(2000);
    checkOutput("first_hs_latency", 32'(first_hs_cyc - start_cyc), 32'd3);
    checkOutput("done_latency", 32'(done_cyc - start_cyc), 32'd1603);
    checkOutput("sweep1_leftover", 32'(exp_q.size()), 32'd0);
    checkOutput("sweep1_count", 32'(hs_count), 32'(DEPTH));

    // Random backpressure
    rnd_mode = 1'b1;
    applyStimulus(1'b1);
    waitDone(6000);
    rnd_mode    = 1'b0;
    bus.m_ready = 1'b1;
    checkOutput("random_leftover", 32'(exp_q.size()), 32'd0);
    checkOutput("random_count", 32'(hs_count), 32'(DEPTH));

    // Long stall right after start, then release
    bus.m_ready = 1'b0;
    base = issued;
    applyStimulus(1'b1);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("stall_reads_issued", 32'(issued - base), 32'd2);
    checkOutput("stall_read_en", 32'(bus.read_en), 32'd0);
    checkOutput("stall_no_handshake", 32'(hs_count), 32'd0);
    bus.m_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("release_rate", 32'(hs_count), 32'd10);
    waitDone(2000);
    checkOutput("stall_leftover", 32'(exp_q.size()), 32'd0);

    // Second start mid-sweep is ignored
    applyStimulus(1'b1);
    waitHs(500, 1000);
    applyStimulus(1'b0);
    waitDone(2000);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("restart_done_count", 32'(done_count), 32'd1);
    checkOutput("restart_busy", 32'(busy), 32'd0);
    checkOutput("restart_leftover", 32'(exp_q.size()), 32'd0);
    checkOutput("restart_count", 32'(hs_count), 32'(DEPTH));

    // Asynchronous reset mid-sweep, then a fresh sweep from address 0
    applyStimulus(1'b1);
    waitHs(800, 1000);
    resetn = 1'b0;
    #1;
    checkReset("async_reset");
    exp_q.delete();
    issued     = 0;
    accepted   = 0;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    done_count = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_no_done", 32'(done_count), 32'd0);
    resetn = 1'b1;
    applyStimulus(1'b1);
    waitDone(2000);
    checkOutput("post_reset_latency", 32'(first_hs_cyc - start_cyc), 32'd3);
    checkOutput("post_reset_leftover", 32'(exp_q.size()), 32'd0);
    checkOutput("post_reset_count", 32'(hs_count), 32'(DEPTH));

    // DEPTH=4 instance with start held high: two back-to-back sweeps
    bus_s.m_ready = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < SMALL_DEPTH; i++) exp_q_s.push_back({(i == SMALL_DEPTH - 1), 8'(i)});
    seen = 0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      @(negedge clk);
      if (done_s) begin
        seen++;
        if (seen == 2) start_s = 1'b0;
      end
    end
    checkOutput("small_two_done", 32'(seen), 32'd2);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("small_leftover", 32'(exp_q_s.size()), 32'd0);
    checkOutput("small_last_count", 32'(last_s), 32'd2);
    checkOutput("small_done_count", 32'(done_count_s), 32'd2);
    checkOutput("small_issued", 32'(issued_s), 32'd8);
    checkOutput("small_busy", 32'(busy_s), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flatten_stream_reader.md
# flatten_stream_reader

Read-side engine for the flattened feature buffer produced by the max-pool/flatten stage. On `start` it sweeps the buffer's byte read port from address 0 to DEPTH−1, absorbs the buffer's one-cycle read latency, and presents the bytes in address order on a valid/ready stream toward the dense (fully-connected) layer. The stream supports backpressure, runs at one byte per cycle when unstalled, and signals completion with `m_last` and a one-cycle `done`.

## Interface
- DEPTH, 1600: number of bytes in the flattened buffer (5×5×64).
- ADDR_W, 32: width of `read_addr`.
- DATA_W, 8: width of `read_data` / `m_data`.
- clk  input  1  single clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
- read_addr  output  ADDR_W  address to the flattened buffer read port.
- read_en  output  1  high in each cycle a read is issued.
- read_data  input  DATA_W  buffer output for the address issued one cycle earlier.
- m_valid  output  1  stream byte available.
- m_ready  input  1  downstream accepts the byte (handshake = m_valid & m_ready).
- m_data  output  DATA_W  stream byte.
- m_last  output  1  high with the byte from address DEPTH−1.
- busy  output  1  high in STREAM and DRAIN.
- done  output  1  one-cycle pulse after the final handshake.

## Operation
- States:
  - IDLE: `start`=1 → STREAM, address counter cleared to 0.
  - STREAM: issue reads 0..DEPTH−1; after the read of DEPTH−1 is issued → DRAIN.
  - DRAIN: wait until no read is in flight and the FIFO is empty → IDLE, with `done` pulsed.
- `start` outside IDLE is ignored. A sweep is never restarted mid-flight.
- The output path is a 2-entry FIFO. `m_data`, `m_valid` and `m_last` come from its head.
- A read is in flight for the one cycle between issue and capture.
- Issue rule: in STREAM, `read_en`=1 iff fifo_count + inflight − (m_valid & m_ready) < 2. The FIFO therefore never overflows.
- `read_addr` holds the current counter value, which increments on each issue. It reads 0 when not busy.
- Every issued read is captured into the FIFO. Bytes are never dropped or duplicated.
- Output ordering is strictly ascending address.
- `m_last` is a sideband bit stored with the byte from address DEPTH−1.

## Timing
- Read latency: `read_data` is captured at the rising edge one cycle after the edge at which `read_addr`/`read_en` were presented.
- Reset values: `read_addr`=0, `read_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0, state IDLE, FIFO empty.
- Reset asserted mid-sweep clears everything immediately. No `done` is produced, and the next sweep restarts at address 0.
- Unstalled timeline (`m_ready`=1 throughout), with `start` sampled at edge E0:
  - `read_en`=1 with addr 0 in cycle after E0.
  - Byte 0 captured at E2.
  - First handshake at E3.
  - Handshake k at E(3+k).
  - Last handshake at E(DEPTH+2), with `m_last`=1.
  - `done`=1 for exactly the cycle following E(DEPTH+2).
  - `busy` falls together with the rise of `done`.
- Stall: while `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable. At most 2 bytes are buffered, and `read_en` drops within one cycle.
- `m_ready` rising after a stall yields one handshake per cycle immediately.
- `done` cycle: the state is already IDLE, so a `start` in that cycle is accepted.
- `m_valid` never asserts without a prior `start`. `m_last` never asserts except on the DEPTH−1 byte.

## Test plan
- Buffer model with latency 1 holding data = addr[7:0]; `m_ready`=1; pulse `start` → 1600 bytes 00,01,…,FF,00,…,3F in order. Also require:
  - First handshake 3 cycles after `start`.
  - `m_last` only on byte 1599 (value 0x3F).
  - `done` one cycle wide, 1603 cycles after `start`.
- Random `m_ready` (50% duty), same data → identical byte sequence with no loss or duplication. Also require:
  - `m_data` stable during every stall.
  - Never more than 2 reads outstanding beyond accepted bytes.
- `m_ready`=0 for 100 cycles right after `start` → exactly 2 reads issued (addr 0,1), then `read_en`=0. On release, byte 00 is followed by 01,02,… one per cycle.
- `start` pulsed again at byte 500 → ignored. The sweep completes once, and exactly one `done` is produced.
- `resetn` low at byte 800 → all outputs reach reset values asynchronously. A new `start` then restarts from addr 0 and delivers the full 1600 bytes.
- DEPTH=4 instance, `start` held high through `done` → back-to-back sweeps. Addresses run 0,1,2,3 then 0,1,2,3, and `m_last` pulses twice.
